// File: rtl/act_lane_pack.sv
// Packs one bf16 element per cycle into LANES-wide vector words with valid/ready handshakes.
// Lanes are flagged as subnormal when the exponent is zero and the mantissa is non-zero.
module act_lane_pack #(
  parameter int I_EXP  = 8,
  parameter int I_MNT  = 7,
  parameter int I_DATA = I_EXP + I_MNT + 1,
  parameter int LANES  = 4,
  parameter int CNT_W  = $clog2(LANES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [I_DATA-1:0]       idata,
  input  logic                    idata_valid,
  input  logic                    idata_last,
  output logic                    idata_ready,
  output logic [LANES*I_DATA-1:0] odata,
  output logic [LANES-1:0]        odata_mask,
  output logic [LANES-1:0]        odata_sub,
  output logic                    odata_last,
  output logic                    odata_valid,
  input  logic                    odata_ready
);

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [0:0]              state_reg;
  logic [I_DATA-1:0]       lane_reg [LANES];
  logic [CNT_W-1:0]        lane_cnt_reg;
  logic [LANES-1:0]        hold_mask_reg;
  logic                    hold_last_reg;

  logic [LANES*I_DATA-1:0] odata_reg;
  logic [LANES-1:0]        odata_mask_reg;
  logic [LANES-1:0]        odata_sub_reg;
  logic                    odata_last_reg;
  logic                    odata_valid_reg;

  logic                    holding;
  logic                    accept;
  logic                    xfer;
  logic                    out_free;
  logic                    complete;
  logic                    load_out;

  logic [LANES-1:0]        src_mask;
  logic [LANES-1:0]        src_sub;
  logic [LANES*I_DATA-1:0] src_data;
  logic [I_DATA-1:0]       src_elem [LANES];

  assign holding     = (state_reg == ST_HOLD);
  assign idata_ready = !rst && !holding;
  assign accept      = idata_valid && idata_ready;
  assign xfer        = odata_valid_reg && odata_ready;
  assign out_free    = !odata_valid_reg || odata_ready;
  assign complete    = accept && ((lane_cnt_reg == CNT_W'(LANES - 1)) || idata_last);
  assign load_out    = (complete && out_free) || (holding && xfer);

  // In FILL the completing element bypasses the lane registers; in HOLD it is already stored.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign src_mask[gi] = holding ? hold_mask_reg[gi] : (CNT_W'(gi) <= lane_cnt_reg);
      assign src_elem[gi] = !src_mask[gi] ? '0 :
                            (holding || (CNT_W'(gi) < lane_cnt_reg)) ? lane_reg[gi] : idata;
      assign src_data[gi*I_DATA +: I_DATA] = src_elem[gi];
      assign src_sub[gi]  = (src_elem[gi][I_DATA-2 -: I_EXP] == '0) &&
                            (src_elem[gi][I_MNT-1:0] != '0);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (accept) begin
      lane_reg[lane_cnt_reg] <= idata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_FILL;
      lane_cnt_reg  <= '0;
      hold_mask_reg <= '0;
      hold_last_reg <= 1'b0;
    end else begin
      if (holding) begin
        if (xfer) begin
          state_reg    <= ST_FILL;
          lane_cnt_reg <= '0;
        end
      end else if (complete) begin
        lane_cnt_reg <= '0;
        if (!out_free) begin
          state_reg     <= ST_HOLD;
          hold_mask_reg <= src_mask;
          hold_last_reg <= idata_last;
        end
      end else if (accept) begin
        lane_cnt_reg <= lane_cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      odata_reg       <= '0;
      odata_mask_reg  <= '0;
      odata_sub_reg   <= '0;
      odata_last_reg  <= 1'b0;
      odata_valid_reg <= 1'b0;
    end else if (load_out) begin
      odata_reg       <= src_data;
      odata_mask_reg  <= src_mask;
      odata_sub_reg   <= src_sub;
      odata_last_reg  <= holding ? hold_last_reg : idata_last;
      odata_valid_reg <= 1'b1;
    end else if (xfer) begin
      odata_valid_reg <= 1'b0;
    end
  end

  assign odata       = odata_reg;
  assign odata_mask  = odata_mask_reg;
  assign odata_sub   = odata_sub_reg;
  assign odata_last  = odata_last_reg;
  assign odata_valid = odata_valid_reg;

endmodule

// File: tb/tb_act_lane_pack.sv
// Directed bench for act_lane_pack: a vector table for the streaming cases plus
// hand-written sequences for backpressure, reset and hold-stability corners.
module tb_act_lane_pack;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] idata;
  logic        idata_valid;
  logic        idata_last;
  logic        idata_ready;
  logic [63:0] odata;
  logic [3:0]  odata_mask;
  logic [3:0]  odata_sub;
  logic        odata_last;
  logic        odata_valid;
  logic        odata_ready;

  always #5 clk = ~clk;

  act_lane_pack dut (
    .clk(clk), .rst(rst),
    .idata(idata), .idata_valid(idata_valid), .idata_last(idata_last), .idata_ready(idata_ready),
    .odata(odata), .odata_mask(odata_mask), .odata_sub(odata_sub), .odata_last(odata_last),
    .odata_valid(odata_valid), .odata_ready(odata_ready)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [15:0] d;
    logic        l;
    logic        emit;
    logic [63:0] vec;
    logic [3:0]  mask;
    logic [3:0]  sub;
    logic        last;
  } row_t;

  row_t tbl[13];
  logic [63:0] exp_vec;
  logic [63:0] held_vec;

  initial begin
    tbl[0]  = '{16'h3F80, 1'b0, 1'b0, 64'h0, 4'h0, 4'h0, 1'b0};
    tbl[1]  = '{16'h4000, 1'b0, 1'b0, 64'h0, 4'h0, 4'h0, 1'b0};
    tbl[2]  = '{16'h4040, 1'b0, 1'b0, 64'h0, 4'h0, 4'h0, 1'b0};
    tbl[3]  = '{16'h4080, 1'b0, 1'b1, 64'h4080_4040_4000_3F80, 4'hF, 4'h0, 1'b0};
    tbl[4]  = '{16'h0001, 1'b0, 1'b0, 64'h0, 4'h0, 4'h0, 1'b0};
    tbl[5]  = '{16'h3E80, 1'b1, 1'b1, 64'h0000_0000_3E80_0001, 4'h3, 4'b0001, 1'b1};
    tbl[6]  = '{16'h8000, 1'b1, 1'b1, 64'h0000_0000_0000_8000, 4'h1, 4'h0, 1'b1};
    tbl[7]  = '{16'h7F80, 1'b1, 1'b1, 64'h0000_0000_0000_7F80, 4'h1, 4'h0, 1'b1};
    tbl[8]  = '{16'h0040, 1'b1, 1'b1, 64'h0000_0000_0000_0040, 4'h1, 4'h1, 1'b1};
    tbl[9]  = '{16'h1111, 1'b0, 1'b0, 64'h0, 4'h0, 4'h0, 1'b0};
    tbl[10] = '{16'h0070, 1'b0, 1'b0, 64'h0, 4'h0, 4'h0, 1'b0};
    tbl[11] = '{16'h3333, 1'b1, 1'b1, 64'h0000_3333_0070_1111, 4'h7, 4'b0010, 1'b1};
    tbl[12] = '{16'h4444, 1'b1, 1'b1, 64'h0000_0000_0000_4444, 4'h1, 4'h0, 1'b1};

    rst = 1'b1; idata = '0; idata_valid = 1'b0; idata_last = 1'b0; odata_ready = 1'b1;
    tick();
    tick();
    chk("rst_ready", 64'(idata_ready), 64'h0);
    chk("rst_valid", 64'(odata_valid), 64'h0);
    chk("rst_odata", odata, 64'h0);
    chk("rst_mask", 64'(odata_mask), 64'h0);
    chk("rst_sub", 64'(odata_sub), 64'h0);
    chk("rst_last", 64'(odata_last), 64'h0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 64'(idata_ready), 64'h1);

    // Streaming table with odata_ready held high.
    for (int i = 0; i < 13; i++) begin
      idata = tbl[i].d; idata_last = tbl[i].l; idata_valid = 1'b1;
      #1;
      chk("tbl_ready", 64'(idata_ready), 64'h1);
      tick();
      $display("row %0d: in=%h last=%b -> valid=%b odata=%h mask=%h sub=%h olast=%b",
               i, tbl[i].d, tbl[i].l, odata_valid, odata, odata_mask, odata_sub, odata_last);
      chk("tbl_valid", 64'(odata_valid), 64'(tbl[i].emit));
      if (tbl[i].emit) begin
        chk("tbl_odata", odata, tbl[i].vec);
        chk("tbl_mask", 64'(odata_mask), 64'(tbl[i].mask));
        chk("tbl_sub", 64'(odata_sub), 64'(tbl[i].sub));
        chk("tbl_last", 64'(odata_last), 64'(tbl[i].last));
      end
    end
    idata_valid = 1'b0; idata_last = 1'b0;
    tick();
    chk("tbl_drain_valid", 64'(odata_valid), 64'h0);

    // Backpressure: two vectors queue up, ninth element stalls.
    odata_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      idata = 16'(i); idata_valid = 1'b1;
      #1;
      chk("bp_ready", 64'(idata_ready), 64'h1);
      tick();
      $display("bp accept %0d: ready=%b valid=%b odata=%h", i, idata_ready, odata_valid, odata);
    end
    chk("bp_stall_ready", 64'(idata_ready), 64'h0);
    chk("bp_vec1", odata, 64'h0004_0003_0002_0001);
    idata = 16'd9;
    tick();
    tick();
    chk("bp_still_stalled", 64'(idata_ready), 64'h0);
    chk("bp_vec1_stable", odata, 64'h0004_0003_0002_0001);
    odata_ready = 1'b1;
    tick();
    chk("bp_vec2", odata, 64'h0008_0007_0006_0005);
    chk("bp_vec2_valid", 64'(odata_valid), 64'h1);
    chk("bp_vec2_mask", 64'(odata_mask), 64'hF);
    chk("bp_ready_back", 64'(idata_ready), 64'h1);
    tick();
    chk("bp_after_vec2", 64'(odata_valid), 64'h0);
    for (int i = 10; i <= 12; i++) begin
      idata = 16'(i);
      tick();
    end
    idata_valid = 1'b0;
    chk("bp_vec3", odata, 64'h000C_000B_000A_0009);
    chk("bp_vec3_valid", 64'(odata_valid), 64'h1);
    tick();

    // Sixteen continuous elements, one vector every fourth cycle.
    exp_vec = '0;
    for (int i = 0; i < 16; i++) begin
      idata = 16'h1000 + 16'(i); idata_valid = 1'b1;
      exp_vec[(i % 4)*16 +: 16] = 16'h1000 + 16'(i);
      #1;
      chk("cont_ready", 64'(idata_ready), 64'h1);
      tick();
      chk("cont_valid", 64'(odata_valid), 64'((i % 4) == 3));
      if ((i % 4) == 3) begin
        $display("cont vector %0d: odata=%h mask=%h", i / 4, odata, odata_mask);
        chk("cont_odata", odata, exp_vec);
        chk("cont_mask", 64'(odata_mask), 64'hF);
      end
    end
    idata_valid = 1'b0;
    tick();

    // Reset after two accepts discards the partial vector.
    idata_valid = 1'b1; idata = 16'hAAAA; tick();
    idata = 16'hBBBB; tick();
    idata_valid = 1'b0; rst = 1'b1;
    #1;
    chk("mid_rst_ready", 64'(idata_ready), 64'h0);
    tick();
    rst = 1'b0;
    tick();
    tick();
    chk("mid_rst_valid", 64'(odata_valid), 64'h0);
    for (int i = 0; i < 4; i++) begin
      idata = 16'h2000 + 16'(i); idata_valid = 1'b1;
      tick();
    end
    idata_valid = 1'b0;
    $display("post-reset vector: odata=%h mask=%h", odata, odata_mask);
    chk("mid_rst_vec", odata, 64'h2003_2002_2001_2000);
    chk("mid_rst_mask", 64'(odata_mask), 64'hF);
    tick();

    // Output holds stable while the consumer stalls.
    odata_ready = 1'b0;
    idata = 16'h0040; idata_last = 1'b1; idata_valid = 1'b1;
    tick();
    idata_valid = 1'b0; idata_last = 1'b0;
    held_vec = odata;
    chk("hold_vec", held_vec, 64'h0000_0000_0000_0040);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_stable", odata, held_vec);
      chk("hold_valid", 64'(odata_valid), 64'h1);
      chk("hold_sub", 64'(odata_sub), 64'h1);
      chk("hold_olast", 64'(odata_last), 64'h1);
    end
    odata_ready = 1'b1;
    tick();
    chk("hold_released", 64'(odata_valid), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
